// File: rtl/cpu_pkg.sv
// cpu_pkg: memory geometry and loader state encoding shared by the core, memory and program loader.
`default_nettype none

package cpu_pkg;

  localparam int WORD_ADDR_W = 7;
  localparam int WORD_W      = 16;
  localparam int BYTE_W      = 8;
  localparam int MEM_WORDS   = 128;

  typedef enum logic [2:0] {
    LD_IDLE  = 3'd0,
    LD_LO    = 3'd1,
    LD_HI    = 3'd2,
    LD_WRITE = 3'd3,
    LD_CHECK = 3'd4,
    LD_DONE  = 3'd5
  } loader_state_t;

endpackage

`default_nettype wire

// File: rtl/prog_loader.sv
// prog_loader: packs a byte stream (low byte first) into words, writes them from address 0,
// verifies a trailing XOR checksum and releases the core only after a clean load.
`default_nettype none

module prog_loader
  import cpu_pkg::*;
#(
  parameter int ADDR_W = WORD_ADDR_W,
  parameter int BYTE_W = cpu_pkg::BYTE_W,
  parameter int WORD_W = cpu_pkg::WORD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        len,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cpu_run
);

  // One extra counter bit lets a full-memory load reach len without wrapping.
  localparam int CNT_W = ADDR_W + 1;
  localparam int DEPTH = 1 << ADDR_W;

  loader_state_t     state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  len_q;
  logic [BYTE_W-1:0] lo_byte;
  logic [BYTE_W-1:0] csum;
  logic [WORD_W-1:0] wdata;
  logic              done_q;
  logic              err_q;
  logic              run_q;

  logic [CNT_W-1:0]  cnt_nxt;
  logic              len_bad;

  assign cnt_nxt = cnt + CNT_W'(1);
  assign len_bad = (len == 8'd0) || (32'(len) > DEPTH);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= LD_IDLE;
      cnt     <= '0;
      len_q   <= '0;
      lo_byte <= '0;
      csum    <= '0;
      wdata   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      case (state)
        LD_IDLE, LD_DONE: begin
          if (start) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            run_q  <= 1'b0;
            csum   <= '0;
            cnt    <= '0;
            len_q  <= CNT_W'(len);
            if (len_bad) begin
              state  <= LD_DONE;
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end else begin
              state <= LD_LO;
            end
          end
        end
        LD_LO: begin
          if (in_valid) begin
            lo_byte <= in_data;
            csum    <= csum ^ in_data;
            state   <= LD_HI;
          end
        end
        LD_HI: begin
          if (in_valid) begin
            wdata <= {in_data, lo_byte};
            csum  <= csum ^ in_data;
            state <= LD_WRITE;
          end
        end
        LD_WRITE: begin
          cnt   <= cnt_nxt;
          state <= (cnt_nxt == len_q) ? LD_CHECK : LD_LO;
        end
        LD_CHECK: begin
          if (in_valid) begin
            done_q <= 1'b1;
            err_q  <= (in_data != csum);
            run_q  <= (in_data == csum);
            state  <= LD_DONE;
          end
        end
        default: state <= LD_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == LD_LO) || (state == LD_HI) || (state == LD_CHECK);
  assign mem_we    = (state == LD_WRITE);
  assign busy      = in_ready || mem_we;
  assign mem_addr  = cnt[ADDR_W-1:0];
  assign mem_wdata = wdata;
  assign done      = done_q;
  assign err       = err_q;
  assign cpu_run   = run_q;

endmodule

`default_nettype wire

// File: tb/tb_prog_loader.sv
// tb_prog_loader: table-driven load scenarios plus hand-written reset/start sequences for prog_loader.
`default_nettype none

module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  len;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [6:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic        cpu_run;

  prog_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .cpu_run   (cpu_run)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         len;
    int         gap;
    logic [7:0] csum;
    logic       exp_err;
    int         exp_cycles;
  } vec_t;

  vec_t        tbl[6];
  logic [7:0]  s3[6];
  logic [15:0] model_mem[128];
  int          wr_cnt   = 0;
  int          rdy_viol = 0;
  int          cyc      = 0;
  int          errors   = 0;
  int          checks   = 0;
  int          t0;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: capture every write strobe seen mid-cycle.
  always @(negedge clk) begin
    if (mem_we) begin
      model_mem[mem_addr] <= mem_wdata;
      wr_cnt <= wr_cnt + 1;
      if (in_ready) rdy_viol <= rdy_viol + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] stream_byte(input int l, input int k);
    return (l == 128) ? 8'(k) : s3[k];
  endfunction

  function automatic logic [15:0] exp_word(input int l, input int i);
    return {stream_byte(l, 2*i+1), stream_byte(l, 2*i)};
  endfunction

  task automatic do_start(input logic [7:0] l);
    start = 1'b1;
    len   = l;
    @(posedge clk); #1;
    start = 1'b0;
    t0    = cyc;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    in_valid = 1'b0;
    in_data  = 8'hEE;
    repeat (gap) begin @(posedge clk); #1; end
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!in_ready) chk("ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 2000) begin @(posedge clk); #1; n++; end
    if (!done) chk("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int   base, viol0;
    logic ok_len;
    base   = wr_cnt;
    viol0  = rdy_viol;
    ok_len = (v.len >= 1) && (v.len <= 128);
    do_start(8'(v.len));
    if (ok_len) begin
      for (int k = 0; k < 2*v.len; k++) send_byte(stream_byte(v.len, k), v.gap);
      send_byte(v.csum, v.gap);
    end
    wait_done();
    if (v.exp_cycles >= 0) chk({tag, "_cycles"}, 32'(cyc - t0), 32'(v.exp_cycles));
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_err"}, 32'(err), 32'(v.exp_err));
    chk({tag, "_cpu_run"}, 32'(cpu_run), 32'(!v.exp_err));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_writes"}, 32'(wr_cnt - base), ok_len ? 32'(v.len) : 32'd0);
    chk({tag, "_ready_in_write"}, 32'(rdy_viol - viol0), 32'd0);
    if (ok_len)
      for (int i = 0; i < v.len; i++)
        chk($sformatf("%s_mem%0d", tag, i), 32'(model_mem[i]), 32'(exp_word(v.len, i)));
  endtask

  initial begin
    s3 = '{8'h0A, 8'h31, 8'h02, 8'h32, 8'h23, 8'h01};
    tbl[0] = '{len: 3,   gap: 0, csum: 8'h29, exp_err: 1'b0, exp_cycles: 10};
    tbl[1] = '{len: 3,   gap: 0, csum: 8'h28, exp_err: 1'b1, exp_cycles: 10};
    tbl[2] = '{len: 3,   gap: 2, csum: 8'h29, exp_err: 1'b0, exp_cycles: -1};
    tbl[3] = '{len: 0,   gap: 0, csum: 8'h00, exp_err: 1'b1, exp_cycles: 0};
    tbl[4] = '{len: 129, gap: 0, csum: 8'h00, exp_err: 1'b1, exp_cycles: 0};
    tbl[5] = '{len: 128, gap: 0, csum: 8'h00, exp_err: 1'b0, exp_cycles: -1};

    rst_n = 1'b0; start = 1'b0; len = 8'd0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs",
        32'({busy, done, err, cpu_run, in_ready, mem_we, mem_addr, mem_wdata}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) run_vec(tbl[i], $sformatf("vec%0d", i));
    chk("mem127", 32'(model_mem[127]), 32'h0000FFFE);

    // A new start after a completed load must clear done and reload.
    do_start(8'd3);
    chk("restart_done_cleared", 32'(done), 32'd0);
    chk("restart_busy", 32'(busy), 32'd1);
    for (int k = 0; k < 6; k++) send_byte(s3[k], 0);
    send_byte(8'h29, 0);
    wait_done();
    chk("restart_err", 32'(err), 32'd0);
    chk("restart_mem0", 32'(model_mem[0]), 32'h310A);

    // Reset mid-load: everything returns to zero, then a fresh load works.
    do_start(8'd3);
    for (int k = 0; k < 3; k++) send_byte(s3[k], 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midload_reset_outputs",
        32'({busy, done, err, cpu_run, in_ready, mem_we, mem_addr, mem_wdata}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_vec(tbl[0], "after_reset");

    // A start pulse while busy (here with an illegal length) is ignored.
    do_start(8'd3);
    send_byte(s3[0], 0);
    send_byte(s3[1], 0);
    start = 1'b1; len = 8'd0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_start_busy", 32'(busy), 32'd1);
    chk("busy_start_done", 32'(done), 32'd0);
    for (int k = 2; k < 6; k++) send_byte(s3[k], 0);
    send_byte(8'h29, 0);
    wait_done();
    chk("busy_start_err", 32'(err), 32'd0);
    chk("busy_start_cpu_run", 32'(cpu_run), 32'd1);
    chk("busy_start_mem2", 32'(model_mem[2]), 32'h0123);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
